// File: rtl/ht_data_table_search_pkg.sv
// Shared hash-table types: command/result codes, data-table entry layout,
// search task/result records and the chain-walk classification helper.
package ht_data_table_search_pkg;

  // Widest configuration the shared records carry; narrower instances zero-extend.
  localparam int HT_KEY_WIDTH   = 32;
  localparam int HT_VALUE_WIDTH = 16;
  localparam int HT_ADDR_WIDTH  = 10;
  localparam int HT_ID_WIDTH    = 4;

  typedef enum logic [1:0] {
    CMD_SEARCH = 2'd0,
    CMD_INSERT = 2'd1,
    CMD_DELETE = 2'd2
  } ht_cmd_t;

  typedef enum logic [31:0] {
    HT_RES_NONE      = 32'd0,
    SEARCH_FOUND     = 32'd1,
    SEARCH_NOT_FOUND = 32'd2,
    INSERT_SUCCESS   = 32'd3,
    INSERT_FAIL      = 32'd4,
    DELETE_SUCCESS   = 32'd5,
    DELETE_NOT_FOUND = 32'd6
  } ht_res_t;

  typedef enum logic [1:0] {
    READ_NO_HEAD               = 2'd0,
    KEY_MATCH                  = 2'd1,
    KEY_NO_MATCH_HAVE_NEXT_PTR = 2'd2,
    GOT_TAIL                   = 2'd3
  } ht_data_table_state_t;

  typedef struct packed {
    logic [HT_KEY_WIDTH-1:0]   key;
    logic [HT_VALUE_WIDTH-1:0] value;
    logic [HT_ADDR_WIDTH-1:0]  next_ptr;
    logic                      next_ptr_val;
  } ht_data_entry_t;

  typedef struct packed {
    logic [HT_KEY_WIDTH-1:0]  key;
    logic [HT_ADDR_WIDTH-1:0] head_ptr;
    logic                     head_ptr_val;
    logic [HT_ID_WIDTH-1:0]   id;
  } ht_search_task_t;

  typedef struct packed {
    ht_res_t                   rescode;
    logic [HT_KEY_WIDTH-1:0]   key;
    logic [HT_VALUE_WIDTH-1:0] value;
    logic [HT_ID_WIDTH-1:0]    id;
    logic [HT_ADDR_WIDTH:0]    hops;
  } ht_search_res_t;

  function automatic ht_data_table_state_t classify(
    input ht_data_entry_t          entry,
    input logic [HT_KEY_WIDTH-1:0] key,
    input logic                    head_val
  );
    ht_data_table_state_t st;
    if (!head_val) begin
      st = READ_NO_HEAD;
    end else if (entry.key == key) begin
      st = KEY_MATCH;
    end else if (entry.next_ptr_val) begin
      st = KEY_NO_MATCH_HAVE_NEXT_PTR;
    end else begin
      st = GOT_TAIL;
    end
    return st;
  endfunction

endpackage

// File: rtl/ht_data_table_search_if.sv
// Task, data-table read port and result channels of the chain-walk stage.
interface ht_data_table_search_if #(
  parameter int KEY_WIDTH        = 32,
  parameter int VALUE_WIDTH      = 16,
  parameter int TABLE_ADDR_WIDTH = 10,
  parameter int ID_WIDTH         = 4
) ();
  logic                        task_valid_i;
  logic                        task_ready_o;
  logic [KEY_WIDTH-1:0]        task_key_i;
  logic [TABLE_ADDR_WIDTH-1:0] task_head_ptr_i;
  logic                        task_head_ptr_val_i;
  logic [ID_WIDTH-1:0]         task_id_i;
  logic                        rd_en_o;
  logic [TABLE_ADDR_WIDTH-1:0] rd_addr_o;
  logic [KEY_WIDTH-1:0]        rd_key_i;
  logic [VALUE_WIDTH-1:0]      rd_value_i;
  logic [TABLE_ADDR_WIDTH-1:0] rd_next_ptr_i;
  logic                        rd_next_ptr_val_i;
  logic                        res_valid_o;
  logic                        res_ready_i;
  logic [31:0]                 res_rescode_o;
  logic [KEY_WIDTH-1:0]        res_key_o;
  logic [VALUE_WIDTH-1:0]      res_value_o;
  logic [ID_WIDTH-1:0]         res_id_o;
  logic [TABLE_ADDR_WIDTH:0]   res_hops_o;
  logic                        loop_err_o;

  modport master (
    output task_valid_i, task_key_i, task_head_ptr_i, task_head_ptr_val_i, task_id_i,
    output rd_key_i, rd_value_i, rd_next_ptr_i, rd_next_ptr_val_i, res_ready_i,
    input  task_ready_o, rd_en_o, rd_addr_o, res_valid_o, res_rescode_o,
    input  res_key_o, res_value_o, res_id_o, res_hops_o, loop_err_o
  );

  modport slave (
    input  task_valid_i, task_key_i, task_head_ptr_i, task_head_ptr_val_i, task_id_i,
    input  rd_key_i, rd_value_i, rd_next_ptr_i, rd_next_ptr_val_i, res_ready_i,
    output task_ready_o, rd_en_o, rd_addr_o, res_valid_o, res_rescode_o,
    output res_key_o, res_value_o, res_id_o, res_hops_o, loop_err_o
  );
endinterface

// File: rtl/ht_data_table_search.sv
// Chain-walk stage: follows a bucket's linked list in the data table until the
// key matches, the tail is reached, or the walk exceeds the table size.
module ht_data_table_search
  import ht_data_table_search_pkg::*;
#(
  parameter int KEY_WIDTH        = 32,
  parameter int VALUE_WIDTH      = 16,
  parameter int TABLE_ADDR_WIDTH = 10,
  parameter int ID_WIDTH         = 4,
  parameter int RD_LATENCY       = 1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  ht_data_table_search_if.slave bus
);

  typedef enum logic [1:0] {ST_IDLE, ST_RD, ST_WAIT, ST_OUT} state_t;

  localparam logic [1:0]                LAT_LAST = 2'(RD_LATENCY - 1);
  localparam logic [TABLE_ADDR_WIDTH:0] HOP_ONE  = (TABLE_ADDR_WIDTH + 1)'(1);
  localparam logic [TABLE_ADDR_WIDTH:0] HOPS_MAX = HOP_ONE << TABLE_ADDR_WIDTH;

  state_t                      r_state, w_next_state;
  logic                        r_rd_en, r_task_ready, r_res_valid, r_loop_err;
  logic [TABLE_ADDR_WIDTH-1:0] r_rd_addr, w_issue_addr;
  logic [1:0]                  r_lat_cnt;
  logic [TABLE_ADDR_WIDTH:0]   r_hops;
  logic [HT_KEY_WIDTH-1:0]     r_key;
  logic [HT_ID_WIDTH-1:0]      r_id;
  ht_search_res_t              r_res;

  ht_search_task_t             w_task;
  ht_data_entry_t              w_entry;
  ht_data_table_state_t        w_head_cls, w_walk_cls;
  ht_res_t                     w_code;
  logic [HT_VALUE_WIDTH-1:0]   w_value;
  logic                        w_accept, w_issue, w_finish, w_loop;

  assign w_accept = bus.task_valid_i & r_task_ready;

  always_comb begin
    w_task              = '0;
    w_task.key          = HT_KEY_WIDTH'(bus.task_key_i);
    w_task.head_ptr     = HT_ADDR_WIDTH'(bus.task_head_ptr_i);
    w_task.head_ptr_val = bus.task_head_ptr_val_i;
    w_task.id           = HT_ID_WIDTH'(bus.task_id_i);
    w_entry              = '0;
    w_entry.key          = HT_KEY_WIDTH'(bus.rd_key_i);
    w_entry.value        = HT_VALUE_WIDTH'(bus.rd_value_i);
    w_entry.next_ptr     = HT_ADDR_WIDTH'(bus.rd_next_ptr_i);
    w_entry.next_ptr_val = bus.rd_next_ptr_val_i;
  end

  always_comb begin
    w_next_state = r_state;
    w_issue      = 1'b0;
    w_issue_addr = r_rd_addr;
    w_finish     = 1'b0;
    w_loop       = 1'b0;
    w_code       = SEARCH_NOT_FOUND;
    w_value      = '0;
    w_head_cls   = classify(w_entry, w_task.key, w_task.head_ptr_val);
    w_walk_cls   = classify(w_entry, r_key, 1'b1);
    case (r_state)
      ST_IDLE: begin
        if (!w_accept) begin
          w_next_state = ST_IDLE;
        end else if (w_head_cls == READ_NO_HEAD) begin
          w_finish     = 1'b1;
          w_next_state = ST_OUT;
        end else begin
          w_issue      = 1'b1;
          w_issue_addr = w_task.head_ptr[TABLE_ADDR_WIDTH-1:0];
          w_next_state = ST_RD;
        end
      end
      ST_RD: w_next_state = ST_WAIT;
      ST_WAIT: begin
        if (r_lat_cnt != LAT_LAST) begin
          w_next_state = ST_WAIT;
        end else begin
          case (w_walk_cls)
            KEY_MATCH: begin
              w_finish     = 1'b1;
              w_code       = SEARCH_FOUND;
              w_value      = w_entry.value;
              w_next_state = ST_OUT;
            end
            KEY_NO_MATCH_HAVE_NEXT_PTR: begin
              // Every address has been visited once already: the chain must loop.
              if (r_hops == HOPS_MAX) begin
                w_finish     = 1'b1;
                w_loop       = 1'b1;
                w_next_state = ST_OUT;
              end else begin
                w_issue      = 1'b1;
                w_issue_addr = w_entry.next_ptr[TABLE_ADDR_WIDTH-1:0];
                w_next_state = ST_RD;
              end
            end
            default: begin
              w_finish     = 1'b1;
              w_next_state = ST_OUT;
            end
          endcase
        end
      end
      ST_OUT: begin
        if (bus.res_ready_i) begin
          w_next_state = ST_IDLE;
        end else begin
          w_next_state = ST_OUT;
        end
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_rd_en       <= 1'b0;
      r_rd_addr     <= '0;
      r_task_ready  <= 1'b0;
      r_loop_err    <= 1'b0;
      r_lat_cnt     <= 2'd0;
      r_hops        <= '0;
      r_key         <= '0;
      r_id          <= '0;
      r_res_valid   <= 1'b0;
      r_res.rescode <= HT_RES_NONE;
      r_res.key     <= '0;
      r_res.value   <= '0;
      r_res.id      <= '0;
      r_res.hops    <= '0;
    end else begin
      r_rd_en      <= w_issue;
      r_loop_err   <= w_loop;
      r_task_ready <= (w_next_state == ST_IDLE);
      if (w_issue) begin
        r_rd_addr <= w_issue_addr;
        r_hops    <= (r_state == ST_IDLE) ? HOP_ONE : r_hops + HOP_ONE;
      end
      if (r_state == ST_RD) begin
        r_lat_cnt <= 2'd0;
      end else if (r_state == ST_WAIT) begin
        r_lat_cnt <= r_lat_cnt + 2'd1;
      end
      if (w_accept) begin
        r_key <= w_task.key;
        r_id  <= w_task.id;
      end
      // A missing head resolves in the accept cycle, before key/id are registered.
      if (w_finish) begin
        r_res_valid   <= 1'b1;
        r_res.rescode <= w_code;
        r_res.value   <= w_value;
        r_res.key     <= (r_state == ST_IDLE) ? w_task.key : r_key;
        r_res.id      <= (r_state == ST_IDLE) ? w_task.id : r_id;
        r_res.hops    <= (r_state == ST_IDLE) ? '0 : (HT_ADDR_WIDTH + 1)'(r_hops);
      end else if ((r_state == ST_OUT) && bus.res_ready_i) begin
        r_res_valid <= 1'b0;
      end
    end
  end

  assign bus.task_ready_o  = r_task_ready;
  assign bus.rd_en_o       = r_rd_en;
  assign bus.rd_addr_o     = r_rd_addr;
  assign bus.res_valid_o   = r_res_valid;
  assign bus.res_rescode_o = r_res.rescode;
  assign bus.res_key_o     = r_res.key[KEY_WIDTH-1:0];
  assign bus.res_value_o   = r_res.value[VALUE_WIDTH-1:0];
  assign bus.res_id_o      = r_res.id[ID_WIDTH-1:0];
  assign bus.res_hops_o    = r_res.hops[TABLE_ADDR_WIDTH:0];
  assign bus.loop_err_o    = r_loop_err;

endmodule
